// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, command bytes, frame edge indices.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    WAIT_IDLE,
    FAIL
  } state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  localparam logic [3:0] LAST_DATA_EDGE = 4'd8;
  localparam logic [3:0] PARITY_EDGE    = 4'd9;
  localparam logic [3:0] STOP_EDGE      = 4'd10;
  localparam logic [3:0] ACK_EDGE       = 4'd11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a clock falling-edge strobe.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ck_in,
  input  logic dt_in,
  output logic ck_sync,
  output logic dt_sync,
  output logic ck_fall
);

  logic [1:0] ck_ff;
  logic [1:0] dt_ff;
  logic       ck_prev;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ck_ff   <= '1;
      dt_ff   <= '1;
      ck_prev <= 1'b1;
    end else begin
      ck_ff   <= {ck_ff[0], ck_in};
      dt_ff   <= {dt_ff[0], dt_in};
      ck_prev <= ck_ff[1];
    end
  end

  assign ck_sync = ck_ff[1];
  assign dt_sync = dt_ff[1];
  assign ck_fall = ck_prev & ~ck_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit odd-parity frame, device ack check.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2ck_in,
  input  logic       ps2dt_in,
  output logic       ps2ck_oe,
  output logic       ps2dt_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nx;
  logic [IW-1:0]   inh_cnt;
  logic [WW-1:0]   wdog;
  logic [3:0]      bit_idx;
  logic [3:0]      edge_nx;
  logic [7:0]      shreg;
  logic            parity;
  logic            dt_drv;
  logic            ck_sync, dt_sync, ck_fall;

  ps2_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .ck_in   (ps2ck_in),
    .dt_in   (ps2dt_in),
    .ck_sync (ck_sync),
    .dt_sync (dt_sync),
    .ck_fall (ck_fall)
  );

  assign edge_nx = bit_idx + 4'd1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ps2ck_oe = 1'b0;
    ps2dt_oe = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      IDLE: if (tx_start) state_nx = INHIBIT;
      INHIBIT: begin
        ps2ck_oe = 1'b1;
        if (inh_cnt == INH_LAST) begin
          ps2dt_oe = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        ps2dt_oe = dt_drv;
        if (wdog == WD_LAST)                       state_nx = FAIL;
        else if (ck_fall && (edge_nx == ACK_EDGE)) state_nx = dt_sync ? FAIL : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (wdog == WD_LAST) state_nx = FAIL;
        else if (ck_sync && dt_sync) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      FAIL: begin
        error    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Data is re-driven the cycle after a detected fall, so it is stable while the device clock is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inh_cnt <= '0;
      wdog    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
      dt_drv  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tx_start) begin
          shreg   <= tx_data;
          parity  <= odd_parity(tx_data);
          inh_cnt <= '0;
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_cnt == INH_LAST) begin
            dt_drv  <= 1'b1;
            bit_idx <= '0;
            wdog    <= '0;
          end
        end
        SEND: begin
          wdog <= wdog + 1'b1;
          if (ck_fall) begin
            bit_idx <= edge_nx;
            if (edge_nx <= LAST_DATA_EDGE)   dt_drv <= ~shreg[bit_idx[2:0]];
            else if (edge_nx == PARITY_EDGE) dt_drv <= ~parity;
            else                             dt_drv <= 1'b0;
          end
        end
        WAIT_IDLE: wdog <= wdog + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain behavioural PS/2 device model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = '0;
  logic       dev_ck_low = 1'b0;
  logic       dev_dt_low = 1'b0;
  logic       ps2ck_oe, ps2dt_oe, busy, done, error;
  logic       ck_line, dt_line;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  int          n, c0;
  bit          saw;
  logic [10:0] fr;

  assign ck_line = ~(ps2ck_oe | dev_ck_low);
  assign dt_line = ~(ps2dt_oe | dev_dt_low);

  ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(2000)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2ck_in (ck_line),
    .ps2dt_in (dt_line),
    .ps2ck_oe (ps2ck_oe),
    .ps2dt_oe (ps2dt_oe),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Request a byte and check the inhibit phase; returns on the first SEND cycle.
  task automatic start_tx(input logic [7:0] d, input bit poke);
    int k;
    logic [9:0] dtm;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_rise", busy, 1);
    k = 0;
    dtm = '0;
    while (ps2ck_oe && k < 100) begin
      if (k < 10) dtm[k] = ps2dt_oe;
      if (poke) tx_start = (k == 3);
      k++;
      @(negedge clk);
    end
    tx_start = 1'b0;
    check("inhibit_len", k, 10);
    check("start_pull", dtm, 10'h200);
    check("start_held", ps2dt_oe, 1);
  endtask

  // Device clocks out `edges` falling edges (20 low / 20 high), sampling before each release.
  task automatic dev_clock(input int edges, input bit ack, input bit poke, output logic [10:0] f);
    f = '0;
    repeat (10) @(negedge clk);
    f[0] = dt_line;
    for (int k = 1; k <= edges; k++) begin
      if (k == 11) begin
        dev_dt_low = ack;
        repeat (10) @(negedge clk);
      end
      dev_ck_low = 1'b1;
      repeat (20) @(negedge clk);
      if (k <= 10) f[k] = dt_line;
      dev_ck_low = 1'b0;
      if (poke && k == 3) begin
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (19) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
    end
    repeat (5) @(negedge clk);
    dev_dt_low = 1'b0;
  endtask

  task automatic wait_end(input int base);
    int k = 0;
    while (done_cnt + err_cnt == base && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("end_seen", (done_cnt + err_cnt) != base, 1);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit p, input bit ack, input bit poke);
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [10:0] f;
    logic [10:0] exp;
    exp = {1'b1, p, d, 1'b0};
    start_tx(d, poke);
    dev_clock(11, ack, poke, f);
    check("frame", f, exp);
    wait_end(d0 + e0);
    repeat (2) @(negedge clk);
    check("done_n", done_cnt - d0, ack);
    check("err_n", err_cnt - e0, !ack);
    check("busy_fall", busy, 0);
    check("oe_idle", {ps2ck_oe, ps2dt_oe}, 0);
  endtask

  initial begin
    // Reset with a pending request
    tx_data  = CMD_RESET;
    tx_start = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_oe", {ps2ck_oe, ps2dt_oe}, 0);
    check("rst_busy", busy, 0);
    tx_start = 1'b0;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_oe", {ps2ck_oe, ps2dt_oe}, 0);
    check("idle_pulses", done_cnt + err_cnt, 0);

    // Normal frames and parity sweep
    run_frame(CMD_SET_LEDS, 1'b1, 1'b1, 1'b0);
    run_frame(8'h00, 1'b1, 1'b1, 1'b0);
    run_frame(8'h01, 1'b0, 1'b1, 1'b0);
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    run_frame(CMD_ENABLE, 1'b0, 1'b1, 1'b0);

    // Missing ack
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0);

    // Watchdog: device never clocks
    c0 = done_cnt;
    start_tx(8'h33, 1'b0);
    n = 0;
    while (!error && n < 2100) begin
      @(negedge clk);
      n++;
    end
    check("wdog_cycles", n, 2000);
    check("wdog_release", {ps2ck_oe, ps2dt_oe}, 0);
    repeat (2) @(negedge clk);
    check("wdog_busy", busy, 0);
    check("wdog_no_done", done_cnt - c0, 0);

    // Repeated tx_start while busy is not queued
    run_frame(8'h12, 1'b1, 1'b1, 1'b1);
    saw = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (busy || ps2ck_oe) saw = 1'b1;
    end
    check("no_requeue", saw, 0);

    // Asynchronous reset mid-frame, then a clean frame
    start_tx(8'h00, 1'b0);
    dev_clock(5, 1'b0, 1'b0, fr);
    repeat (3) @(negedge clk);
    check("pre_rst_dt", ps2dt_oe, 1);
    c0 = done_cnt + err_cnt;
    #2 rst = 1'b0;
    #1;
    check("async_rst_oe", {ps2ck_oe, ps2dt_oe}, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_pulse", done_cnt + err_cnt - c0, 0);
    run_frame(CMD_ENABLE, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
